// File: rtl/three_way_toom_cook_seq.sv
// ---------------------------------------------------------------------------------------------
// three_way_toom_cook_seq
//   Sequenced GF(2)[x] multiplier using a 3-way split of each operand. The inputs are split into
//   three S-bit slices, and a single shared bit-serial lane works out the nine slice products
//   ai*bj one bit per cycle. Each product is XOR-accumulated into one of five term registers
//   T0..T4, where Tk holds the sum of ai*bj over i+j=k. A final COMBINE step folds the terms into
//   the 2N-bit product. Latency is fixed: 9*S + 1 edges from accepted start to the COMBINE edge.
//
// Ports
//   i_clk    in   1    clock, rising edge
//   i_rst    in   1    synchronous active-high reset
//   i_start  in   1    request, honoured only in IDLE
//   i_a      in   N    operand A, latched on accepted start
//   i_b      in   N    operand B, latched on accepted start
//   o_busy   out  1    high in every state except IDLE
//   o_done   out  1    one-cycle pulse, o_c valid from this cycle
//   o_c      out  2N   carry-less product; holds until the next COMBINE
// ---------------------------------------------------------------------------------------------
module three_way_toom_cook_seq #(
  parameter int unsigned N = 571
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_c
);

  localparam int unsigned S  = (N + 2) / 3;          // slice width
  localparam int unsigned W  = 3 * S;                // padded operand width
  localparam int unsigned TW = 2 * S - 1;            // term width
  localparam int unsigned CW = 2 * N;                // product width
  localparam int unsigned FW = 6 * S + 1;            // recombination width, always > CW
  localparam int unsigned BW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StCombine, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [W-1:0]     r_a, r_b;
  logic [4:0][TW-1:0] r_t;
  logic [3:0]       r_pair;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_c;

  logic [W-1:0]     w_a_pad, w_b_pad;
  logic [1:0]       w_i, w_j;
  logic [2:0]       w_k;
  logic [S-1:0]     w_a_slice, w_b_slice;
  logic             w_a_bit;
  logic [TW-1:0]    w_b_ext, w_b_shift;
  logic             w_last_bit, w_last_step;
  logic [FW-1:0]    w_full;
  logic             w_unused_hi;

  // Zero-pad operands up to three full slices.
  always_comb begin
    w_a_pad          = '0;
    w_b_pad          = '0;
    w_a_pad[N-1:0]   = i_a;
    w_b_pad[N-1:0]   = i_b;
  end

  // Serial lane: select slices for the current pair and the partial product for this bit.
  always_comb begin
    w_i = 2'(r_pair / 4'd3);
    w_j = 2'(r_pair % 4'd3);
    w_k = {1'b0, w_i} + {1'b0, w_j};

    w_a_slice = r_a[S-1:0];
    unique case (w_i)
      2'd1:    w_a_slice = r_a[2*S-1:S];
      2'd2:    w_a_slice = r_a[3*S-1:2*S];
      default: w_a_slice = r_a[S-1:0];
    endcase

    w_b_slice = r_b[S-1:0];
    unique case (w_j)
      2'd1:    w_b_slice = r_b[2*S-1:S];
      2'd2:    w_b_slice = r_b[3*S-1:2*S];
      default: w_b_slice = r_b[S-1:0];
    endcase

    w_a_bit            = w_a_slice[r_bit];
    w_b_ext            = '0;
    w_b_ext[S-1:0]     = w_b_slice;
    // bit <= S-1, so the shifted slice never exceeds TW bits.
    w_b_shift          = w_b_ext << r_bit;

    w_last_bit  = (r_bit == BW'(S - 1));
    w_last_step = w_last_bit && (r_pair == 4'd8);
  end

  // Recombination: c = XOR_k Tk << k*S. Bits above 2N-1 are structurally zero for N <= 3S.
  always_comb begin
    w_full = '0;
    for (int k = 0; k < 5; k++) begin
      w_full[k*S +: TW] = w_full[k*S +: TW] ^ r_t[k];
    end
    w_unused_hi = ^w_full[FW-1:CW];
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_start) w_state_next = StMul;
      StMul:     if (w_last_step) w_state_next = StCombine;
      StCombine: w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy = 1'b1;
    o_done = 1'b0;
    unique case (r_state)
      StIdle:  o_busy = 1'b0;
      StDone:  o_done = 1'b1;
      default: o_busy = 1'b1;
    endcase
  end

  // Datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_t    <= '0;
      r_pair <= '0;
      r_bit  <= '0;
      r_c    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_a    <= w_a_pad;
            r_b    <= w_b_pad;
            r_t    <= '0;
            r_pair <= '0;
            r_bit  <= '0;
          end
        end
        StMul: begin
          // No zero-bit skipping: every step costs one cycle regardless of data.
          if (w_a_bit) begin
            r_t[w_k] <= r_t[w_k] ^ w_b_shift;
          end
          if (w_last_bit) begin
            r_bit  <= '0;
            r_pair <= r_pair + 4'd1;
          end else begin
            r_bit  <= r_bit + BW'(1);
          end
        end
        StCombine: r_c <= w_full[CW-1:0];
        default: ;
      endcase
    end
  end

  assign o_c = r_c;

endmodule

// File: tb/tb_three_way_toom_cook_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_three_way_toom_cook_seq
//   Directed bench for the sequenced 3-way GF(2)[x] multiplier at N = 571. Expected products are
//   hand-derived constants or come from a plain bit-by-bit carry-less multiply.
// ---------------------------------------------------------------------------------------------
module tb_three_way_toom_cook_seq;

  localparam int unsigned N   = 571;
  localparam int unsigned S   = (N + 2) / 3;
  localparam int unsigned CW  = 2 * N;
  localparam int unsigned LAT = 9 * S + 1;   // edges from start edge to the COMBINE edge

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  a, b;
  logic          busy, done;
  logic [CW-1:0] c;

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] last_c;

  always #5 clk = ~clk;

  three_way_toom_cook_seq #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_c     (c)
  );

  function automatic logic [CW-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [CW-1:0] r;
    logic [CW-1:0] ye;
    r  = '0;
    ye = '0;
    ye[N-1:0] = y;
    for (int i = 0; i < N; i++) begin
      if (x[i]) r = r ^ (ye << i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start at edge 0, optionally poke start mid-run, then hold start during DONE.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [CW-1:0] exp, input int poke_at);
    int   cyc;
    logic busy_gap;
    logic c_moved;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Operands may change freely once accepted.
    a = ~av;
    b = av ^ bv;
    cyc      = 0;
    busy_gap = 1'b0;
    c_moved  = 1'b0;
    while (!done && cyc < int'(LAT) + 10) begin
      if (!busy) busy_gap = 1'b1;
      if (c !== last_c) c_moved = 1'b1;
      start = (cyc == poke_at);
      tick();
      start = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, CW'(cyc), CW'(LAT));
    chk({tag, " busy through run"}, CW'(busy_gap), CW'(0));
    chk({tag, " c held until combine"}, CW'(c_moved), CW'(0));
    chk({tag, " busy with done"}, CW'(busy), CW'(1));
    chk({tag, " product"}, c, exp);
    last_c = exp;
    // A start during DONE must not be queued.
    start = 1'b1;
    a     = '1;
    b     = '1;
    tick();
    start = 1'b0;
    chk({tag, " done single pulse"}, CW'(done), CW'(0));
    chk({tag, " idle after done"}, CW'(busy), CW'(0));
    chk({tag, " c stable in idle"}, c, exp);
  endtask

  initial begin
    logic [N-1:0]  ra, rb;
    logic [CW-1:0] e;
    logic          saw_done;

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    last_c = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1: idle after reset.
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("reset no done", CW'(saw_done), CW'(0));
    chk("reset busy", CW'(busy), CW'(0));
    chk("reset c", c, '0);

    // 2: 1 * 1.
    run_op("one", N'(1), N'(1), CW'(1), -1);

    // 3: top bit of each operand: x^570 * x^570 = x^1140.
    ra = '0;
    ra[N-1] = 1'b1;
    e = '0;
    e[2*N-2] = 1'b1;
    run_op("topbit", ra, ra, e, -1);

    // 4: all ones squared over GF(2) keeps only the even powers 0..1140.
    e = '0;
    for (int i = 0; i < int'(N); i++) e[2*i] = 1'b1;
    run_op("allones", '1, '1, e, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        ra[i] = 1'($urandom_range(1, 0));
        rb[i] = 1'($urandom_range(1, 0));
      end
      run_op($sformatf("rand%0d", r), ra, rb, clmul(ra, rb), -1);
    end

    // 5: start poked at edge 100 mid-MUL, and during DONE, both ignored; back-to-back op follows.
    run_op("poke", N'(32'h0000_00ff), N'(32'h0000_0101), CW'(32'h0000_ffff), 99);
    run_op("zero", '0, '1, '0, -1);

    // 6: reset at edge 500 mid-MUL aborts without a done pulse and clears c.
    a     = '1;
    b     = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (499) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", CW'(busy), CW'(0));
    chk("abort done", CW'(done), CW'(0));
    chk("abort c", c, '0);
    last_c   = '0;
    saw_done = 1'b0;
    for (int i = 0; i < int'(LAT) + 5; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("abort stays idle", CW'(saw_done), CW'(0));
    run_op("three_five", N'(3), N'(5), CW'(15), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
